mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multicycle MIPS control unit: Moore FSM sequences the shared datapath (one memory, one ALU) through
//  fetch/decode/execute/writeback. Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi, j, ori, lui.
//  Sits beside the multicycle datapath in top; also counts retired instructions.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter instret
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      asynchronous, active-high
//  op          in   6      instr[31:26] from instruction register
//  funct       in   6      instr[5:0]
//  zero        in   1      ALU zero flag
//  pcen        out  1      pcwrite | (branch & zero)
//  irwrite     out  1      load instruction register
//  regwrite    out  1      register file write
//  memwrite    out  1      data memory write
//  iord        out  1      0=PC, 1=ALUOut as memory address
//  memtoreg    out  1      1=memory data to regfile
//  regdst      out  1      1=rd, 0=rt
//  alusrca     out  1      0=PC, 1=A
//  alusrcb     out  2      00=B, 01=4, 10=imm, 11=sext(imm)<<2
//  immsrc      out  2      00=sign-ext, 01=zero-ext, 10=imm<<16
//  pcsrc       out  2      00=ALU result, 01=ALUOut, 10=jump target
//  alucontrol  out  3      000 and, 001 or, 010 add, 110 sub, 011 slt
//  illegal     out  1      one-cycle pulse on undecodable instruction
//  retire      out  1      one-cycle pulse in last state of each instruction
//  instret     out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=FETCH, instret=0, illegal=0; pcwrite/irwrite/regwrite/memwrite forced 0 while reset high.
//  All outputs decode from state (Moore); only RTYPEEX alucontrol also uses funct (stable; IR loads only in FETCH).
//  Unlisted outputs are 0; alucontrol defaults to 010.
//  FETCH   : irwrite=1, pcwrite=1, alusrcb=01, add                      -> DECODE
//  DECODE  : alusrcb=11, add (branch target into ALUOut)
//            op 100011/101011->MEMADR, 000000->RTYPEEX, 000100->BEQEX, 001000->ADDIEX,
//            000010->JEX, 001101->ORIEX, 001111->LUIEX; else illegal=1 -> FETCH.
//            op=000000 with funct not in {100000,100010,100100,100101,101010}: illegal=1 -> FETCH
//  MEMADR  : alusrca=1, alusrcb=10, immsrc=00, add  -> MEMRD if lw, MEMWR if sw
//  MEMRD   : iord=1 -> MEMWB;  MEMWB: memtoreg=1, regwrite=1, retire=1 -> FETCH
//  MEMWR   : iord=1, memwrite=1, retire=1 -> FETCH
//  RTYPEEX : alusrca=1, alusrcb=00, alucontrol from funct -> ALUWB
//  ALUWB   : regdst=1, regwrite=1, retire=1 -> FETCH
//  BEQEX   : alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1, retire=1 -> FETCH
//  ADDIEX  : alusrca=1, alusrcb=10, immsrc=00, add -> IWB
//  ORIEX   : alusrca=1, alusrcb=10, immsrc=01, or  -> IWB
//  LUIEX   : alusrca=1, alusrcb=10, immsrc=10, or (rs=$0) -> IWB
//  IWB     : regdst=0, regwrite=1, retire=1 -> FETCH
//  JEX     : pcsrc=10, pcwrite=1, retire=1 -> FETCH
//  Latency: lw 5, sw/R/addi/ori/lui 4, beq/j 3 cycles. Illegal op costs 2 cycles, not retired.
//  instret increments on the clock edge where retire=1; wraps all-ones->0.
//  pcen combinational; zero only matters in BEQEX (branch=1). Undefined state encodings -> FETCH.
//  Reset asserted mid-instruction: immediate return to FETCH, no pending write occurs after reset rises.
// TESTING
//  1 reset, op=100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite+memtoreg only in cycle 5; instret=1
//  2 op=101011 -> memwrite=1,iord=1 in cycle 4 only; regwrite never 1; instret increments once
//  3 op=000000 funct=100010 -> alucontrol=110 in cycle 3, regdst=1 regwrite=1 in cycle 4
//  4 op=000100: zero=1 -> pcen=1 in cycle 3, pcsrc=01; zero=0 -> pcen=0 in cycle 3
//  5 op=001111 then op=001101 -> LUIEX immsrc=10, ORIEX immsrc=01 alucontrol=001, IWB regdst=0 regwrite=1; instret=2
//  6 op=111111 -> illegal pulse in DECODE, back to FETCH, instret unchanged; reset in MEMRD -> FETCH, no regwrite

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control unit: Moore FSM that sequences a shared-memory, shared-ALU datapath
// through fetch/decode/execute/writeback and counts retired instructions.
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pcen,
    output logic             irwrite,
    output logic             regwrite,
    output logic             memwrite,
    output logic             iord,
    output logic             memtoreg,
    output logic             regdst,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       immsrc,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] instret
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b011;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        IWB     = 4'd10,
        JEX     = 4'd11,
        ORIEX   = 4'd12,
        LUIEX   = 4'd13
    } state_t;

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
            default:                                                funct_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu = ALU_ADD;
        endcase
    endfunction

    state_t           state_r, state_s;
    logic             pcwrite_s, branch_s, irwrite_s, regwrite_s, memwrite_s;
    logic             iord_s, memtoreg_s, regdst_s, alusrca_s, illegal_s, retire_s;
    logic [1:0]       alusrcb_s, immsrc_s, pcsrc_s;
    logic [2:0]       alucontrol_s;
    logic [CNT_W-1:0] instret_r;

    // State register; asynchronous reset returns straight to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and Moore output decode; only RTYPEEX looks at funct for the ALU operation.
    always_comb begin
        state_s      = FETCH;
        pcwrite_s    = 1'b0;
        branch_s     = 1'b0;
        irwrite_s    = 1'b0;
        regwrite_s   = 1'b0;
        memwrite_s   = 1'b0;
        iord_s       = 1'b0;
        memtoreg_s   = 1'b0;
        regdst_s     = 1'b0;
        alusrca_s    = 1'b0;
        alusrcb_s    = 2'b00;
        immsrc_s     = 2'b00;
        pcsrc_s      = 2'b00;
        alucontrol_s = ALU_ADD;
        illegal_s    = 1'b0;
        retire_s     = 1'b0;
        case (state_r)
            FETCH: begin
                irwrite_s = 1'b1;
                pcwrite_s = 1'b1;
                alusrcb_s = 2'b01;
                state_s   = DECODE;
            end
            DECODE: begin
                alusrcb_s = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_s = MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal(funct)) begin
                            state_s = RTYPEEX;
                        end else begin
                            illegal_s = 1'b1;
                            state_s   = FETCH;
                        end
                    end
                    OP_BEQ:  state_s = BEQEX;
                    OP_ADDI: state_s = ADDIEX;
                    OP_J:    state_s = JEX;
                    OP_ORI:  state_s = ORIEX;
                    OP_LUI:  state_s = LUIEX;
                    default: begin
                        illegal_s = 1'b1;
                        state_s   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                if (op == OP_LW) begin
                    state_s = MEMRD;
                end else if (op == OP_SW) begin
                    state_s = MEMWR;
                end else begin
                    state_s = FETCH;
                end
            end
            MEMRD: begin
                iord_s  = 1'b1;
                state_s = MEMWB;
            end
            MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            RTYPEEX: begin
                alusrca_s    = 1'b1;
                alucontrol_s = funct_alu(funct);
                state_s      = ALUWB;
            end
            ALUWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            BEQEX: begin
                alusrca_s    = 1'b1;
                alucontrol_s = ALU_SUB;
                pcsrc_s      = 2'b01;
                branch_s     = 1'b1;
                retire_s     = 1'b1;
            end
            ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                state_s   = IWB;
            end
            ORIEX: begin
                alusrca_s    = 1'b1;
                alusrcb_s    = 2'b10;
                immsrc_s     = 2'b01;
                alucontrol_s = ALU_OR;
                state_s      = IWB;
            end
            LUIEX: begin
                // rs is $0, so OR with the shifted immediate yields imm<<16.
                alusrca_s    = 1'b1;
                alusrcb_s    = 2'b10;
                immsrc_s     = 2'b10;
                alucontrol_s = ALU_OR;
                state_s      = IWB;
            end
            IWB: begin
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            JEX: begin
                pcsrc_s   = 2'b10;
                pcwrite_s = 1'b1;
                retire_s  = 1'b1;
            end
            default: begin
                state_s = FETCH;
            end
        endcase
    end

    // Retired-instruction counter, wraps naturally at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_r <= '0;
        end else if (retire_s) begin
            instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instret_r <= instret_r;
        end
    end

    // State-changing strobes are masked while reset is high so FETCH cannot write during reset.
    assign pcen       = (pcwrite_s | (branch_s & zero)) & ~reset;
    assign irwrite    = irwrite_s & ~reset;
    assign regwrite   = regwrite_s & ~reset;
    assign memwrite   = memwrite_s & ~reset;
    assign illegal    = illegal_s & ~reset;
    assign retire     = retire_s & ~reset;
    assign iord       = iord_s;
    assign memtoreg   = memtoreg_s;
    assign regdst     = regdst_s;
    assign alusrca    = alusrca_s;
    assign alusrcb    = alusrcb_s;
    assign immsrc     = immsrc_s;
    assign pcsrc      = pcsrc_s;
    assign alucontrol = alucontrol_s;
    assign instret    = instret_r;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: a reference model pushes per-cycle expected outputs,
// which are popped and compared against the DUT on each falling edge.
module tb_mc_ctrl_fsm;

    localparam int TW = 3;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4;
    localparam int S_MEMWR = 5, S_RTYPEEX = 6, S_ALUWB = 7, S_BEQEX = 8, S_ADDIEX = 9;
    localparam int S_IWB = 10, S_JEX = 11, S_ORIEX = 12, S_LUIEX = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    op = 6'b000000;
    logic [5:0]    funct = 6'b100000;
    logic          zero = 1'b0;
    logic          pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0]    alusrcb, immsrc, pcsrc;
    logic [2:0]    alucontrol;
    logic          illegal, retire;
    logic [TW-1:0] instret;

    logic [18:0]   got;
    logic [18:0]   q[$];
    logic [TW-1:0] model_cnt;
    int            checks = 0;
    int            errors = 0;

    mc_ctrl_fsm #(.CNT_W(TW)) dut (
        .clk(clk), .reset(rst), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .immsrc(immsrc), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .illegal(illegal), .retire(retire), .instret(instret)
    );

    always #5 clk = ~clk;

    assign got = {pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
                  alusrcb, immsrc, pcsrc, alucontrol, illegal, retire};

    function automatic logic legal(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b001101, 6'b001111: legal = 1'b1;
            6'b000000: legal = (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
                               (f == 6'b100101) || (f == 6'b101010);
            default:   legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'b100010: r_alu = 3'b110;
            6'b100100: r_alu = 3'b000;
            6'b100101: r_alu = 3'b001;
            6'b101010: r_alu = 3'b011;
            default:   r_alu = 3'b010;
        endcase
    endfunction

    function automatic int m_next(input int st, input logic [5:0] o, input logic [5:0] f);
        m_next = S_FETCH;
        case (st)
            S_FETCH:  m_next = S_DECODE;
            S_DECODE: begin
                if (!legal(o, f))           m_next = S_FETCH;
                else if (o == 6'b100011 || o == 6'b101011) m_next = S_MEMADR;
                else if (o == 6'b000000)    m_next = S_RTYPEEX;
                else if (o == 6'b000100)    m_next = S_BEQEX;
                else if (o == 6'b001000)    m_next = S_ADDIEX;
                else if (o == 6'b000010)    m_next = S_JEX;
                else if (o == 6'b001101)    m_next = S_ORIEX;
                else                        m_next = S_LUIEX;
            end
            S_MEMADR:  m_next = (o == 6'b100011) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   m_next = S_MEMWB;
            S_RTYPEEX: m_next = S_ALUWB;
            S_ADDIEX, S_ORIEX, S_LUIEX: m_next = S_IWB;
            default:   m_next = S_FETCH;
        endcase
    endfunction

    // {pcen,irwrite,regwrite,memwrite,iord,memtoreg,regdst,alusrca,alusrcb,immsrc,pcsrc,alu,illegal,retire}
    function automatic logic [18:0] m_out(input int st, input logic [5:0] o, input logic [5:0] f,
                                          input logic z);
        logic [7:0] fl;
        logic [1:0] sb, im, ps;
        logic [2:0] alu;
        logic       il, rt;
        fl = 8'h00; sb = 2'b00; im = 2'b00; ps = 2'b00; alu = 3'b010; il = 1'b0; rt = 1'b0;
        case (st)
            S_FETCH:   begin fl = 8'b1100_0000; sb = 2'b01; end
            S_DECODE:  begin sb = 2'b11; il = !legal(o, f); end
            S_MEMADR:  begin fl = 8'b0000_0001; sb = 2'b10; end
            S_MEMRD:   begin fl = 8'b0000_1000; end
            S_MEMWB:   begin fl = 8'b0010_0100; rt = 1'b1; end
            S_MEMWR:   begin fl = 8'b0001_1000; rt = 1'b1; end
            S_RTYPEEX: begin fl = 8'b0000_0001; alu = r_alu(f); end
            S_ALUWB:   begin fl = 8'b0010_0010; rt = 1'b1; end
            S_BEQEX:   begin fl = {z, 7'b000_0001}; alu = 3'b110; ps = 2'b01; rt = 1'b1; end
            S_ADDIEX:  begin fl = 8'b0000_0001; sb = 2'b10; end
            S_ORIEX:   begin fl = 8'b0000_0001; sb = 2'b10; im = 2'b01; alu = 3'b001; end
            S_LUIEX:   begin fl = 8'b0000_0001; sb = 2'b10; im = 2'b10; alu = 3'b001; end
            S_IWB:     begin fl = 8'b0010_0000; rt = 1'b1; end
            S_JEX:     begin fl = 8'b1000_0000; ps = 2'b10; rt = 1'b1; end
            default:   begin fl = 8'h00; end
        endcase
        m_out = {fl, sb, im, ps, alu, il, rt};
    endfunction

    // Precondition: just after the edge that entered FETCH, before its falling edge.
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int stop_after);
        int st;
        int n;
        logic [18:0] e;
        op = o; funct = f; zero = z;
        st = S_FETCH; n = 0;
        do begin
            e = m_out(st, o, f, z);
            q.push_back(e);
            if (e[0]) model_cnt = model_cnt + 3'd1;
            st = m_next(st, o, f);
            n++;
        end while (st != S_FETCH && n < 8 && n < stop_after);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs got %b expected %b", name, k + 1, got, e);
            end
            if (k < n - 1) begin
                @(posedge clk); #1;
            end
        end
        if (n >= stop_after) return;
        @(posedge clk); #1;
        checks++;
        if (instret !== model_cnt) begin
            errors++;
            $display("FAIL %s instret: got %0d expected %0d", name, instret, model_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_cnt = '0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({pcen, irwrite, regwrite, memwrite, illegal, instret} !== {5'b00000, 3'd0}) begin
                errors++;
                $display("FAIL reset: strobes/instret got %b/%0d expected 00000/0",
                         {pcen, irwrite, regwrite, memwrite, illegal}, instret);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_mem();
        run_instr("lw", 6'b100011, 6'b000000, 1'($urandom_range(0, 1)), 99);
        run_instr("sw", 6'b101011, 6'b111111, 1'($urandom_range(0, 1)), 99);
    endtask

    task automatic test_rtype();
        logic [5:0] fs [5];
        fs = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010};
        foreach (fs[i]) run_instr("rtype", 6'b000000, fs[i], 1'($urandom_range(0, 1)), 99);
    endtask

    task automatic test_branch_jump();
        run_instr("beq_taken", 6'b000100, 6'b000000, 1'b1, 99);
        run_instr("beq_not_taken", 6'b000100, 6'b000000, 1'b0, 99);
        run_instr("j", 6'b000010, 6'b101010, 1'b1, 99);
    endtask

    task automatic test_imm();
        run_instr("lui", 6'b001111, 6'b000000, 1'b0, 99);
        run_instr("ori", 6'b001101, 6'b000000, 1'b1, 99);
        run_instr("addi", 6'b001000, 6'b100010, 1'b0, 99);
    endtask

    task automatic test_illegal();
        run_instr("illegal_op", 6'b111111, 6'b100000, 1'b0, 99);
        run_instr("illegal_funct", 6'b000000, 6'b000001, 1'b0, 99);
    endtask

    task automatic test_reset_mid();
        run_instr("lw_cut", 6'b100011, 6'b000000, 1'b0, 4);
        rst = 1'b1;
        model_cnt = '0;
        #1;
        checks++;
        if ({pcen, irwrite, regwrite, memwrite, instret} !== {4'b0000, 3'd0}) begin
            errors++;
            $display("FAIL reset_mid: strobes/instret got %b/%0d expected 0000/0",
                     {pcen, irwrite, regwrite, memwrite}, instret);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({regwrite, memwrite} !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid_hold: regwrite/memwrite got %b expected 00",
                         {regwrite, memwrite});
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr("after_reset_lw", 6'b100011, 6'b000000, 1'b1, 99);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [9];
        logic [5:0] fs  [5];
        int oi;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                6'b000010, 6'b001101, 6'b001111, 6'b110011};
        fs  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int i = 0; i < 24; i++) begin
            oi = int'($urandom_range(0, 8));
            run_instr("b2b", ops[oi], fs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), 99);
        end
    endtask

    initial begin
        test_reset();
        test_mem();
        test_rtype();
        test_branch_jump();
        test_imm();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
